serial_adder: RTL and testbench

- Parametrised digit-serial adder/subtractor; the multi-cycle successor of the 8-bit combinational full adder.
- Processes SLICE bits per clock, LSB first, through a start/busy/done handshake.
- Trades latency for area in datapath blocks where a full WIDTH-bit carry chain does not close timing.
- Adds over the previous generation: subtract mode, signed-overflow flag, registered held results.

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 153 +++++++++++++++
 tb/tb_serial_adder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// The master side issues requests; the slave side is the adder itself.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cy_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] y_o;
    logic             cy_o;
    logic             ov_o;

    modport master (
        output start_i, sub_i, a_i, b_i, cy_i,
        input  busy_o, done_o, y_o, cy_o, ov_o
    );

    modport slave (
        input  start_i, sub_i, a_i, b_i, cy_i,
        output busy_o, done_o, y_o, cy_o, ov_o
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: SLICE bits per clock, LSB first, start/busy/done handshake.
// Optional unsigned saturation at completion is enabled by defining SERIAL_ADDER_SAT_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    serial_adder_if.slave   bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             sub_q,   sub_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] y_q,     y_d;
    logic             cy_q,    cy_d;
    logic             ov_q,    ov_d;

    logic [31:0]      base_s;
    logic [SLICE-1:0] slice_a_s;
    logic [SLICE-1:0] slice_b_s;
    logic [SLICE:0]   slice_sum_s;
    logic [WIDTH-1:0] sum_full_s;
    logic             cy_fin_s;
    logic             ov_fin_s;
    logic [WIDTH-1:0] y_fin_s;

    // Current slice sum and the completed result as it would look after this edge
    always_comb begin
        base_s      = 32'(cnt_q) * 32'(SLICE);
        slice_a_s   = a_q[base_s +: SLICE];
        slice_b_s   = b_q[base_s +: SLICE];
        slice_sum_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE{1'b0}}, carry_q};
        sum_full_s  = acc_q;
        sum_full_s[base_s +: SLICE] = slice_sum_s[SLICE-1:0];
        // B is held pre-inverted for subtract, so the add-carry is the inverted borrow
        cy_fin_s    = sub_q ? ~slice_sum_s[SLICE] : slice_sum_s[SLICE];
        ov_fin_s    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_full_s[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SERIAL_ADDER_SAT_EN
        if (cy_fin_s) begin
            y_fin_s = sub_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end else begin
            y_fin_s = sum_full_s;
        end
`else
        y_fin_s     = sum_full_s;
`endif
    end

    // Next-state and datapath update for the IDLE/RUN controller
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_d     = y_q;
        cy_d    = cy_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.sub_i ? ~bus.b_i : bus.b_i;
                    sub_d   = bus.sub_i;
                    carry_d = bus.sub_i ? ~bus.cy_i : bus.cy_i;
                    cnt_d   = {CW{1'b0}};
                    acc_d   = {WIDTH{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d   = sum_full_s;
                carry_d = slice_sum_s[SLICE];
                if (cnt_q == CNT_LAST) begin
                    y_d     = y_fin_s;
                    cy_d    = cy_fin_s;
                    ov_d    = ov_fin_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                cnt_d   = {CW{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            acc_q   <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= {WIDTH{1'b0}};
            cy_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            cy_q    <= cy_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.y_o    = y_q;
    assign bus.cy_o   = cy_q;
    assign bus.ov_o   = ov_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8, SLICE=2) against an integer-arithmetic model.
// Expectations follow SERIAL_ADDER_SAT_EN when it is defined for the build.
module tb_serial_adder;
    localparam int WIDTH  = 8;
    localparam int SLICE  = 2;
    localparam int NSLICE = WIDTH / SLICE;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    logic sat_en;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: plain integer add/subtract, borrow from sign of the difference
    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b,
                                   input logic sub, input logic cy,
                                   output logic [7:0] y, output logic c, output logic v);
        int r;
        if (!sub) begin
            r = int'(a) + int'(b) + int'(cy);
            c = (r > 255);
            y = 8'(r);
            v = (a[7] == b[7]) && (y[7] != a[7]);
        end else begin
            r = int'(a) - int'(b) - int'(cy);
            c = (r < 0);
            y = 8'(r);
            v = (a[7] != b[7]) && (y[7] != a[7]);
        end
        if (sat_en && c) y = sub ? 8'h00 : 8'hFF;
    endfunction

    // Issue one request (caller is 1 time unit after a rising edge) and wait for done_o
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic cy, output int lat, output logic busy_seen);
        logic seen;
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.sub_i   = sub;
        bus.cy_i    = cy;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.a_i     = 8'($urandom);
        bus.b_i     = 8'($urandom);
        bus.sub_i   = 1'($urandom);
        bus.cy_i    = 1'($urandom);
        busy_seen   = bus.busy_o;
        lat  = -1;
        seen = 1'b0;
        for (int k = 1; k <= 4 * NSLICE + 4; k++) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (bus.done_o) begin
                    lat  = k;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.sub_i = 1'b0; bus.cy_i = 1'b0;
        bus.a_i = 8'd0; bus.b_i = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
        checks++; if (bus.y_o !== 8'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", bus.y_o); end
        checks++; if (bus.cy_o !== 1'b0) begin errors++; $display("FAIL reset_cy got=%b exp=0", bus.cy_o); end
        checks++; if (bus.ov_o !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", bus.ov_o); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] ta[9]     = '{8'd100, 8'd100, 8'd255, 8'd127, 8'd5, 8'd200, 8'd128, 8'd200, 8'd3};
        logic [7:0] tb_[9]    = '{8'd155, 8'd155, 8'd255, 8'd1,   8'd7, 8'd100, 8'd1,   8'd100, 8'd10};
        logic       tsub[9]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       tcy[9]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] ty_wrap[9]= '{8'd0,   8'd255, 8'd255, 8'd128, 8'd254, 8'd99, 8'd127, 8'd44,  8'd249};
        logic [7:0] ty_sat[9] = '{8'd255, 8'd255, 8'd255, 8'd128, 8'd0,   8'd99, 8'd127, 8'd255, 8'd0};
        logic       tco[9]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       tov[9]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int lat; logic bs; logic [7:0] ey; logic [7:0] yh;
        for (int i = 0; i < 9; i++) begin
            do_op(ta[i], tb_[i], tsub[i], tcy[i], lat, bs);
            ey = sat_en ? ty_sat[i] : ty_wrap[i];
            checks++; if (bs !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got=%b exp=1", i, bs); end
            checks++; if (lat != NSLICE) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NSLICE); end
            checks++; if (bus.y_o !== ey) begin errors++; $display("FAIL dir%0d_y got=%0d exp=%0d", i, bus.y_o, ey); end
            checks++; if (bus.cy_o !== tco[i]) begin errors++; $display("FAIL dir%0d_cy got=%b exp=%b", i, bus.cy_o, tco[i]); end
            checks++; if (bus.ov_o !== tov[i]) begin errors++; $display("FAIL dir%0d_ov got=%b exp=%b", i, bus.ov_o, tov[i]); end
            yh = bus.y_o;
            @(posedge clk); #1;
            checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, bus.done_o); end
            checks++; if (bus.y_o !== ey) begin errors++; $display("FAIL dir%0d_y_hold got=%0d exp=%0d", i, bus.y_o, ey); end
        end
    endtask

    task automatic test_random();
        int lat; logic bs; logic [7:0] a, b, ey; logic s, c, ec, ev;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); c = 1'($urandom);
            ref_op(a, b, s, c, ey, ec, ev);
            do_op(a, b, s, c, lat, bs);
            checks++; if (lat != NSLICE) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, NSLICE); end
            checks++; if (bus.y_o !== ey || bus.cy_o !== ec || bus.ov_o !== ev) begin
                errors++;
                $display("FAIL rnd%0d_result a=%0d b=%0d sub=%b cy=%b got y=%0d cy=%b ov=%b exp y=%0d cy=%b ov=%b",
                         i, a, b, s, c, bus.y_o, bus.cy_o, bus.ov_o, ey, ec, ev);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic bs; logic seen; logic [7:0] yprev, ey; logic ec, ev; int c0;
        yprev = bus.y_o;
        bus.start_i = 1'b1; bus.a_i = 8'd10; bus.b_i = 8'd20; bus.sub_i = 1'b0; bus.cy_i = 1'b0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.a_i = 8'd200; bus.b_i = 8'd50; bus.sub_i = 1'b1; bus.cy_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        checks++; if (bus.y_o !== yprev) begin errors++; $display("FAIL busy_y_stable got=%0d exp=%0d", bus.y_o, yprev); end
        lat = 2; seen = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (bus.done_o) begin lat = k; seen = 1'b1; end
            end
        end
        checks++; if (!seen || lat != NSLICE) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", seen ? lat : -1, NSLICE); end
        checks++; if (bus.y_o !== 8'd30) begin errors++; $display("FAIL ignore_y got=%0d exp=30", bus.y_o); end
        c0 = cyc;
        do_op(8'd200, 8'd100, 1'b0, 1'b0, lat, bs);
        ref_op(8'd200, 8'd100, 1'b0, 1'b0, ey, ec, ev);
        checks++; if (cyc - c0 != NSLICE + 1) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", cyc - c0, NSLICE + 1); end
        checks++; if (bus.y_o !== ey || bus.cy_o !== ec) begin errors++; $display("FAIL b2b_result got y=%0d cy=%b exp y=%0d cy=%b", bus.y_o, bus.cy_o, ey, ec); end
    endtask

    task automatic test_reset_mid();
        int lat; logic bs; int ndone;
        bus.start_i = 1'b1; bus.a_i = 8'd50; bus.b_i = 8'd60; bus.sub_i = 1'b0; bus.cy_i = 1'b0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.y_o !== 8'd0) begin errors++; $display("FAIL midrst_y got=%0d exp=0", bus.y_o); end
        checks++; if (bus.cy_o !== 1'b0) begin errors++; $display("FAIL midrst_cy got=%b exp=0", bus.cy_o); end
        checks++; if (bus.ov_o !== 1'b0) begin errors++; $display("FAIL midrst_ov got=%b exp=0", bus.ov_o); end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.done_o) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
        do_op(8'd1, 8'd1, 1'b0, 1'b0, lat, bs);
        checks++; if (lat != NSLICE) begin errors++; $display("FAIL after_rst_latency got=%0d exp=%0d", lat, NSLICE); end
        checks++; if (bus.y_o !== 8'd2) begin errors++; $display("FAIL after_rst_y got=%0d exp=2", bus.y_o); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
`ifdef SERIAL_ADDER_SAT_EN
        sat_en = 1'b1;
`else
        sat_en = 1'b0;
`endif
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
